// File: rtl/riscv_pkg.sv
// Shared ALU operation codes and the memory/writeback control bundle
// used by the ID/EX operand stage.
package riscv_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_JAL = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0110;
  localparam logic [3:0] ALU_SRA = 4'b0111;
  localparam logic [3:0] ALU_EQ  = 4'b1000;
  localparam logic [3:0] ALU_NE  = 4'b1001;
  localparam logic [3:0] ALU_LT  = 4'b1010;
  localparam logic [3:0] ALU_GE  = 4'b1011;
  localparam logic [3:0] ALU_SLT = 4'b1100;
  localparam logic [3:0] ALU_SUB = 4'b1111;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
  } ctrl_t;

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// Bundle of decode-side inputs, producer (EX/MEM, MEM/WB) results and ALU-side
// outputs of the ID/EX operand stage.
interface id_ex_operand_stage_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int REG_ADDR_W    = 5,
  parameter int CTRL_W        = 4
);
  logic                     stall;
  logic                     flush;
  logic                     id_valid;
  logic [DATA_WIDTH-1:0]    id_pc;
  logic [DATA_WIDTH-1:0]    id_rd1;
  logic [DATA_WIDTH-1:0]    id_rd2;
  logic [DATA_WIDTH-1:0]    id_imm;
  logic [REG_ADDR_W-1:0]    id_rs1;
  logic [REG_ADDR_W-1:0]    id_rs2;
  logic [REG_ADDR_W-1:0]    id_rd;
  logic [OPCODE_LENGTH-1:0] id_alu_op;
  logic                     id_alusrc_a;
  logic                     id_alusrc_b;
  logic [CTRL_W-1:0]        id_ctrl;

  logic                     exmem_reg_write;
  logic                     memwb_reg_write;
  logic [REG_ADDR_W-1:0]    exmem_rd;
  logic [REG_ADDR_W-1:0]    memwb_rd;
  logic [DATA_WIDTH-1:0]    exmem_result;
  logic [DATA_WIDTH-1:0]    memwb_result;

  logic [DATA_WIDTH-1:0]    SrcA;
  logic [DATA_WIDTH-1:0]    SrcB;
  logic [OPCODE_LENGTH-1:0] Operation;
  logic [DATA_WIDTH-1:0]    ex_store_data;
  logic [DATA_WIDTH-1:0]    ex_pc;
  logic [REG_ADDR_W-1:0]    ex_rd;
  logic [CTRL_W-1:0]        ex_ctrl;
  logic                     ex_valid;
  logic                     load_use_hazard;

  modport master (
    output stall, flush, id_valid, id_pc, id_rd1, id_rd2, id_imm, id_rs1, id_rs2,
           id_rd, id_alu_op, id_alusrc_a, id_alusrc_b, id_ctrl,
           exmem_reg_write, memwb_reg_write, exmem_rd, memwb_rd,
           exmem_result, memwb_result,
    input  SrcA, SrcB, Operation, ex_store_data, ex_pc, ex_rd, ex_ctrl,
           ex_valid, load_use_hazard
  );

  modport slave (
    input  stall, flush, id_valid, id_pc, id_rd1, id_rd2, id_imm, id_rs1, id_rs2,
           id_rd, id_alu_op, id_alusrc_a, id_alusrc_b, id_ctrl,
           exmem_reg_write, memwb_reg_write, exmem_rd, memwb_rd,
           exmem_result, memwb_result,
    output SrcA, SrcB, Operation, ex_store_data, ex_pc, ex_rd, ex_ctrl,
           ex_valid, load_use_hazard
  );
endinterface

// File: rtl/forward_unit.sv
// Resolves one source operand: newest matching producer wins, x0 is hard zero,
// otherwise the value captured from the register file.
module forward_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [DATA_WIDTH-1:0] reg_data,
  input  logic                  exmem_reg_write,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic [DATA_WIDTH-1:0] exmem_result,
  input  logic                  memwb_reg_write,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic [DATA_WIDTH-1:0] memwb_result,
  output logic [DATA_WIDTH-1:0] operand
);

  always_comb begin
    operand = reg_data;
    if (rs == '0) begin
      operand = '0;
    end else if (exmem_reg_write && (exmem_rd == rs)) begin
      operand = exmem_result;
    end else if (memwb_reg_write && (memwb_rd == rs)) begin
      operand = memwb_result;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding, load-use detection,
// stall hold and flush bubbles, feeding SrcA/SrcB/Operation to the ALU.
module id_ex_operand_stage
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int REG_ADDR_W    = 5,
  parameter int CTRL_W        = 4
) (
  input logic clk,
  input logic reset,
  id_ex_operand_stage_if.slave bus
);

  logic                     valid_reg;
  logic [DATA_WIDTH-1:0]    pc_reg;
  logic [DATA_WIDTH-1:0]    rd1_reg;
  logic [DATA_WIDTH-1:0]    rd2_reg;
  logic [DATA_WIDTH-1:0]    imm_reg;
  logic [REG_ADDR_W-1:0]    rs1_reg;
  logic [REG_ADDR_W-1:0]    rs2_reg;
  logic [REG_ADDR_W-1:0]    rd_reg;
  logic [OPCODE_LENGTH-1:0] op_reg;
  logic                     alusrc_a_reg;
  logic                     alusrc_b_reg;
  ctrl_t                    ctrl_reg;

  logic [REG_ADDR_W-1:0]    rs_sel [2];
  logic [DATA_WIDTH-1:0]    data_sel [2];
  logic [DATA_WIDTH-1:0]    fwd [2];
  logic                     hazard;

  assign rs_sel[0]   = rs1_reg;
  assign rs_sel[1]   = rs2_reg;
  assign data_sel[0] = rd1_reg;
  assign data_sel[1] = rd2_reg;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      forward_unit #(
        .DATA_WIDTH(DATA_WIDTH),
        .REG_ADDR_W(REG_ADDR_W)
      ) u_forward_unit (
        .rs              (rs_sel[gi]),
        .reg_data        (data_sel[gi]),
        .exmem_reg_write (bus.exmem_reg_write),
        .exmem_rd        (bus.exmem_rd),
        .exmem_result    (bus.exmem_result),
        .memwb_reg_write (bus.memwb_reg_write),
        .memwb_rd        (bus.memwb_rd),
        .memwb_result    (bus.memwb_result),
        .operand         (fwd[gi])
      );
    end
  endgenerate

  // A flush kills the consumer too, so the hazard must not also hold ID.
  always_comb begin
    hazard = 1'b0;
    if (!bus.flush && bus.id_valid && valid_reg && ctrl_reg.mem_read &&
        (rd_reg != '0) && ((rd_reg == bus.id_rs1) || (rd_reg == bus.id_rs2))) begin
      hazard = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_reg    <= 1'b0;
      pc_reg       <= '0;
      rd1_reg      <= '0;
      rd2_reg      <= '0;
      imm_reg      <= '0;
      rs1_reg      <= '0;
      rs2_reg      <= '0;
      rd_reg       <= '0;
      op_reg       <= '0;
      alusrc_a_reg <= 1'b0;
      alusrc_b_reg <= 1'b0;
      ctrl_reg     <= '0;
    end else if (bus.flush || (!bus.stall && hazard)) begin
      valid_reg <= 1'b0;
      ctrl_reg  <= '0;
      rd_reg    <= '0;
      op_reg    <= '0;
    end else if (bus.stall) begin
      // Capture forwarded values so they outlive producers that retire mid-stall.
      rd1_reg <= fwd[0];
      rd2_reg <= fwd[1];
    end else begin
      valid_reg    <= bus.id_valid;
      pc_reg       <= bus.id_pc;
      rd1_reg      <= bus.id_rd1;
      rd2_reg      <= bus.id_rd2;
      imm_reg      <= bus.id_imm;
      rs1_reg      <= bus.id_rs1;
      rs2_reg      <= bus.id_rs2;
      rd_reg       <= bus.id_rd;
      op_reg       <= bus.id_alu_op;
      alusrc_a_reg <= bus.id_alusrc_a;
      alusrc_b_reg <= bus.id_alusrc_b;
      ctrl_reg     <= ctrl_t'(bus.id_ctrl);
    end
  end

  assign bus.SrcA            = alusrc_a_reg ? pc_reg : fwd[0];
  assign bus.SrcB            = alusrc_b_reg ? imm_reg : fwd[1];
  assign bus.ex_store_data   = fwd[1];
  assign bus.Operation       = op_reg;
  assign bus.ex_pc           = pc_reg;
  assign bus.ex_rd           = rd_reg;
  assign bus.ex_ctrl         = ctrl_reg;
  assign bus.ex_valid        = valid_reg;
  assign bus.load_use_hazard = hazard;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench: stimulus pushes cycle-tagged expectations into a scoreboard,
// a negedge monitor pops and compares them against the stage outputs.
module tb_id_ex_operand_stage;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  id_ex_operand_stage_if bus ();

  id_ex_operand_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef enum {S_VALID, S_CTRL, S_RD, S_SRCA, S_SRCB, S_OP, S_STORE, S_PC, S_HZ} sig_e;
  typedef struct {
    int          cyc;
    sig_e        sig;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(sig_e s);
    case (s)
      S_VALID: return {31'd0, bus.ex_valid};
      S_CTRL:  return {28'd0, bus.ex_ctrl};
      S_RD:    return {27'd0, bus.ex_rd};
      S_SRCA:  return bus.SrcA;
      S_SRCB:  return bus.SrcB;
      S_OP:    return {28'd0, bus.Operation};
      S_STORE: return bus.ex_store_data;
      S_PC:    return bus.ex_pc;
      default: return {31'd0, bus.load_use_hazard};
    endcase
  endfunction

  always @(negedge clk) begin
    logic [31:0] a;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        checks++;
        a = actual(sb[i].sig);
        if (sb[i].cyc < cyc) begin
          errors++;
          $display("FAIL %s: not observed at cycle %0d", sb[i].name, sb[i].cyc);
        end else if (a !== sb[i].val) begin
          errors++;
          $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                   sb[i].name, a, sb[i].val, cyc);
        end else begin
          $display("ok   %s = 0x%0h (cycle %0d)", sb[i].name, a, cyc);
        end
        sb.delete(i);
      end
    end
  end

  task automatic expect_sig(int dc, sig_e s, logic [31:0] v, string n);
    exp_t e;
    e.cyc = cyc + dc;
    e.sig = s;
    e.val = v;
    e.name = n;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(logic v, logic [31:0] pc, logic [31:0] r1, logic [31:0] r2,
                        logic [31:0] imm, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                        logic [3:0] op, logic sa, logic sbsel, logic [3:0] ctrl);
    bus.id_valid    = v;
    bus.id_pc       = pc;
    bus.id_rd1      = r1;
    bus.id_rd2      = r2;
    bus.id_imm      = imm;
    bus.id_rs1      = rs1;
    bus.id_rs2      = rs2;
    bus.id_rd       = rd;
    bus.id_alu_op   = op;
    bus.id_alusrc_a = sa;
    bus.id_alusrc_b = sbsel;
    bus.id_ctrl     = ctrl;
  endtask

  task automatic set_prod(logic ew, logic [4:0] erd, logic [31:0] eres,
                          logic mw, logic [4:0] mrd, logic [31:0] mres);
    bus.exmem_reg_write = ew;
    bus.exmem_rd        = erd;
    bus.exmem_result    = eres;
    bus.memwb_reg_write = mw;
    bus.memwb_rd        = mrd;
    bus.memwb_result    = mres;
  endtask

  initial begin
    reset     = 1'b0;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    set_id(1, 32'h40, 32'h11, 32'h22, 32'h33, 5'd1, 5'd2, 5'd3, ALU_ADD, 0, 0, 4'b1000);
    set_prod(0, 0, 0, 0, 0, 0);

    // Reset held two cycles with a valid instruction presented.
    tick();  // cyc 1
    expect_sig(0, S_VALID, 0, "rst_valid");
    expect_sig(0, S_CTRL,  0, "rst_ctrl");
    expect_sig(0, S_SRCA,  0, "rst_srca");
    expect_sig(0, S_SRCB,  0, "rst_srcb");
    tick();  // cyc 2
    expect_sig(0, S_RD, 0, "rst_rd");
    expect_sig(0, S_OP, 0, "rst_op");
    expect_sig(0, S_PC, 0, "rst_pc");
    expect_sig(0, S_HZ, 0, "rst_hz");

    // ADDI x6, x1, 7
    reset = 1'b1;
    set_id(1, 32'h100, 32'h5, 32'h99, 32'h7, 5'd1, 5'd2, 5'd6, ALU_ADD, 0, 1, 4'b1000);
    expect_sig(1, S_SRCA,  32'h5,   "addi_srca");
    expect_sig(1, S_SRCB,  32'h7,   "addi_srcb");
    expect_sig(1, S_OP,    32'h2,   "addi_op");
    expect_sig(1, S_VALID, 1,       "addi_valid");
    expect_sig(1, S_CTRL,  32'h8,   "addi_ctrl");
    expect_sig(1, S_PC,    32'h100, "addi_pc");
    expect_sig(1, S_STORE, 32'h99,  "addi_store");
    tick();  // cyc 3
    set_id(1, 32'h104, 32'h01, 32'h77, 0, 5'd3, 5'd0, 5'd7, ALU_OR, 0, 0, 4'b1000);

    tick();  // cyc 4: both producers target rs1=3, EX/MEM must win
    set_prod(1, 5'd3, 32'hAA, 1, 5'd3, 32'hBB);
    expect_sig(0, S_SRCA,  32'hAA, "dfwd_srca");
    expect_sig(0, S_SRCB,  0,      "dfwd_x0_srcb");
    expect_sig(0, S_STORE, 0,      "dfwd_x0_store");
    expect_sig(0, S_OP,    32'h1,  "dfwd_op");
    set_id(1, 32'h108, 32'h12, 32'h34, 0, 5'd0, 5'd3, 5'd8, ALU_XOR, 0, 0, 4'b1000);

    tick();  // cyc 5: rs1=x0 with rd=0 producers
    set_prod(1, 5'd0, 32'hCC, 1, 5'd0, 32'hDD);
    expect_sig(0, S_SRCA, 0,      "x0_srca");
    expect_sig(0, S_SRCB, 32'h34, "nofwd_srcb");
    set_id(1, 32'h10C, 32'h90, 32'hA0, 0, 5'd9, 5'd10, 5'd9, ALU_SLL, 0, 0, 4'b1000);

    tick();  // cyc 6: MEM/WB feeds rs1, EX/MEM feeds rs2
    set_prod(1, 5'd10, 32'hE1, 1, 5'd9, 32'hF1);
    expect_sig(0, S_SRCA,  32'hF1, "memwb_srca");
    expect_sig(0, S_SRCB,  32'hE1, "exmem_srcb");
    expect_sig(0, S_STORE, 32'hE1, "exmem_store");
    set_id(1, 32'h110, 32'h200, 0, 32'h4, 5'd1, 5'd0, 5'd4, ALU_ADD, 0, 1, 4'b1101);

    tick();  // cyc 7: lw x4 in EX, consumer reads x4 as rs2
    set_prod(0, 0, 0, 0, 0, 0);
    set_id(1, 32'h114, 32'h500, 32'h4, 0, 5'd5, 5'd4, 5'd10, ALU_ADD, 0, 0, 4'b1000);
    expect_sig(0, S_HZ,    1,       "lu_hz");
    expect_sig(0, S_VALID, 1,       "lw_valid");
    expect_sig(0, S_CTRL,  32'hD,   "lw_ctrl");
    expect_sig(0, S_RD,    32'h4,   "lw_rd");
    expect_sig(0, S_SRCA,  32'h200, "lw_srca");
    expect_sig(0, S_SRCB,  32'h4,   "lw_srcb");
    expect_sig(1, S_VALID, 0, "lu_bubble_valid");
    expect_sig(1, S_CTRL,  0, "lu_bubble_ctrl");
    expect_sig(1, S_RD,    0, "lu_bubble_rd");
    expect_sig(1, S_HZ,    0, "lu_bubble_hz");

    tick();  // cyc 8: held consumer now enters
    expect_sig(1, S_VALID, 1,      "lu_retry_valid");
    expect_sig(1, S_RD,    32'hA,  "lu_retry_rd");
    expect_sig(1, S_CTRL,  32'h8,  "lu_retry_ctrl");

    tick();  // cyc 9: loaded value forwarded from MEM/WB
    set_prod(0, 0, 0, 1, 5'd4, 32'h4444);
    expect_sig(0, S_SRCB,  32'h4444, "lu_fwd_srcb");
    expect_sig(0, S_STORE, 32'h4444, "lu_fwd_store");
    expect_sig(0, S_SRCA,  32'h500,  "lu_fwd_srca");
    set_id(1, 32'h118, 32'h600, 0, 0, 5'd6, 5'd0, 5'd11, ALU_XOR, 0, 0, 4'b1000);

    tick();  // cyc 10: stall, MEM/WB forwards only this cycle
    bus.stall = 1'b1;
    set_prod(0, 0, 0, 1, 5'd6, 32'h55);
    set_id(1, 32'h11C, 32'hBAD, 0, 0, 5'd11, 5'd0, 5'd12, ALU_SUB, 0, 0, 4'b1101);
    expect_sig(0, S_SRCA, 32'h55, "stall1_srca");
    tick();  // cyc 11
    set_prod(0, 0, 0, 0, 0, 0);
    expect_sig(0, S_SRCA, 32'h55, "stall2_srca");
    expect_sig(0, S_OP,   32'h6,  "stall2_op");
    expect_sig(0, S_RD,   32'hB,  "stall2_rd");
    tick();  // cyc 12
    expect_sig(0, S_SRCA, 32'h55, "stall3_srca");
    tick();  // cyc 13: release
    bus.stall = 1'b0;
    expect_sig(0, S_SRCA, 32'h55,  "release_srca");
    expect_sig(1, S_OP,   32'hF,   "next_op");
    expect_sig(1, S_RD,   32'hC,   "next_rd");
    expect_sig(1, S_SRCA, 32'hBAD, "next_srca");
    expect_sig(1, S_CTRL, 32'hD,   "next_ctrl");

    tick();  // cyc 14: flush+stall while a load-use pair is present
    bus.flush = 1'b1;
    bus.stall = 1'b1;
    set_id(1, 32'h120, 32'h1, 32'h2, 0, 5'd12, 5'd0, 5'd13, ALU_OR, 0, 0, 4'b1000);
    expect_sig(0, S_HZ,    0, "flush_hz");
    expect_sig(1, S_VALID, 0, "flush_valid");
    expect_sig(1, S_CTRL,  0, "flush_ctrl");
    expect_sig(1, S_RD,    0, "flush_rd");

    tick();  // cyc 15
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    expect_sig(0, S_HZ,    0,     "post_flush_hz");
    expect_sig(1, S_VALID, 1,     "post_flush_valid");
    expect_sig(1, S_RD,    32'hD, "post_flush_rd");

    tick();  // cyc 16: idle ID loads an invalid slot
    set_id(0, 0, 0, 0, 0, 0, 0, 0, ALU_AND, 0, 0, 4'b0000);
    expect_sig(1, S_VALID, 0, "idle_valid");

    tick();
    tick();
    tick();
    if (sb.size() != 0) begin
      checks += sb.size();
      errors += sb.size();
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
